// File: rtl/aes_pkg.sv
// Shared AES definitions for the InvMixColumns datapath: GF(2^8) helpers,
// InvMixColumns coefficients and the FSM state encoding.
package aes_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_BUSY = 2'd1;
    localparam fsm_state_t ST_DONE = 2'd2;

    // Coefficients never exceed 0x0f, so four bits select the xtime terms.
    localparam logic [3:0] INV_C_0E = 4'he;
    localparam logic [3:0] INV_C_0B = 4'hb;
    localparam logic [3:0] INV_C_0D = 4'hd;
    localparam logic [3:0] INV_C_09 = 4'h9;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? a  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column, row 0 in the top byte.
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;

    assign {a0, a1, a2, a3} = col_in;

    assign r0 = gf_mul_const(a0, INV_C_0E) ^ gf_mul_const(a1, INV_C_0B) ^
                gf_mul_const(a2, INV_C_0D) ^ gf_mul_const(a3, INV_C_09);
    assign r1 = gf_mul_const(a0, INV_C_09) ^ gf_mul_const(a1, INV_C_0E) ^
                gf_mul_const(a2, INV_C_0B) ^ gf_mul_const(a3, INV_C_0D);
    assign r2 = gf_mul_const(a0, INV_C_0D) ^ gf_mul_const(a1, INV_C_09) ^
                gf_mul_const(a2, INV_C_0E) ^ gf_mul_const(a3, INV_C_0B);
    assign r3 = gf_mul_const(a0, INV_C_0B) ^ gf_mul_const(a1, INV_C_0D) ^
                gf_mul_const(a2, INV_C_09) ^ gf_mul_const(a3, INV_C_0E);

    assign col_out = {r0, r1, r2, r3};

endmodule

// File: rtl/inv_mix_columns.sv
// Iterative InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock,
// transforming a working register in place.
module inv_mix_columns
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output fsm_state_t   fsm_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; once out_valid rises, out_valid and state_out hold until that edge.

    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_OFS = 2'(COLS_PER_CYCLE - 1);

    fsm_state_t   state;
    logic [1:0]   cnt;
    logic [127:0] work;
    logic [127:0] work_next;
    logic         last_step;

    logic [1:0]  col_idx [COLS_PER_CYCLE];
    logic [31:0] col_sel [COLS_PER_CYCLE];
    logic [31:0] col_res [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_idx[g] = cnt + 2'(g);

        always_comb begin
            col_sel[g] = work[127:96];
            case (col_idx[g])
                2'd0:    col_sel[g] = work[127:96];
                2'd1:    col_sel[g] = work[95:64];
                2'd2:    col_sel[g] = work[63:32];
                default: col_sel[g] = work[31:0];
            endcase
        end

        inv_mix_column u_col (
            .col_in  (col_sel[g]),
            .col_out (col_res[g])
        );
    end

    always_comb begin
        work_next = work;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            case (col_idx[k])
                2'd0:    work_next[127:96] = col_res[k];
                2'd1:    work_next[95:64]  = col_res[k];
                2'd2:    work_next[63:32]  = col_res[k];
                default: work_next[31:0]   = col_res[k];
            endcase
        end
    end

    // The step that covers column 3 is the final one for this block.
    assign last_step = ((cnt + LAST_OFS) == 2'd3);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
            work  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work  <= state_in;
                        cnt   <= 2'd0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    work <= work_next;
                    cnt  <= cnt + STEP;
                    if (last_step) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE) && reset;
    assign out_valid = (state == ST_DONE);
    assign state_out = work;
    assign fsm_state = state;

endmodule

// File: tb/tb_inv_mix_columns.sv
// Self-checking bench for inv_mix_columns at COLS_PER_CYCLE = 1, 2 and 4,
// checked against a polynomial-arithmetic GF(2^8) reference model.
module tb_inv_mix_columns;
  import aes_pkg::*;

  logic         clk;
  logic         reset;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] state_in  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] state_out [3];
  fsm_state_t   fsm_state [3];

  int n_checks;
  int n_fail;
  logic [127:0] exp_q[$];

  // ---------------- clock / reset / DUTs ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_columns #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .state_in  (state_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .state_out (state_out[g]),
      .fsm_state (fsm_state[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model_mix(input logic [127:0] blk, input bit inverse);
    logic [7:0] base [4];
    logic [7:0] a [4];
    logic [7:0] r;
    logic [127:0] res;
    if (inverse) begin
      base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    end else begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = blk[127 - 32*c - 8*j -: 8];
      for (int i = 0; i < 4; i++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++) r = r ^ gmul(base[(j - i) & 3], a[j]);
        res[127 - 32*c - 8*i -: 8] = r;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver ----------------
  task automatic send_block(input int d, input logic [127:0] blk,
                            output logic [127:0] res, output int lat, output bit ok);
    int waited;
    ok = 1'b0;
    lat = 0;
    res = '0;
    @(negedge clk);
    waited = 0;
    while (!in_ready[d] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready[d]) begin
      n_checks++; n_fail++;
      $display("FAIL send_ready dut%0d: in_ready=%b expected 1", d, in_ready[d]);
      return;
    end
    in_valid[d] = 1'b1;
    state_in[d] = blk;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid[d]) begin
        lat = i;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL out_valid_timeout dut%0d: out_valid=%b expected 1 within 20 cycles", d, out_valid[d]);
      return;
    end
    res = state_out[d];
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0 || state_out[d] !== '0 || fsm_state[d] !== ST_IDLE) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: in_ready=%b out_valid=%b state_out=%h fsm=%0d expected 0 0 0 IDLE",
                 d, in_ready[d], out_valid[d], state_out[d], fsm_state[d]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (in_ready[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_release_ready dut%0d: in_ready=%b expected 1", d, in_ready[d]);
      end
    end
  endtask

  task automatic test_single();
    logic [127:0] blk, want, res;
    int lat;
    bit ok;
    blk  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    want = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    for (int d = 0; d < 3; d++) begin
      send_block(d, blk, res, lat, ok);
      if (ok) begin
        n_checks++;
        if (lat !== (4 >> d)) begin
          n_fail++;
          $display("FAIL single_latency dut%0d: latency=%0d expected %0d", d, lat, 4 >> d);
        end
        n_checks++;
        if (res !== want) begin
          n_fail++;
          $display("FAIL single_result dut%0d: got %h expected %h", d, res, want);
        end
      end
    end
  endtask

  task automatic test_fixed_point();
    logic [127:0] blk, res;
    int lat;
    bit ok;
    for (int p = 0; p < 2; p++) begin
      blk = (p == 0) ? {16{8'hc6}} : {16{8'h01}};
      for (int d = 0; d < 3; d++) begin
        send_block(d, blk, res, lat, ok);
        if (ok) begin
          n_checks++;
          if (res !== blk) begin
            n_fail++;
            $display("FAIL fixed_point dut%0d: got %h expected %h", d, res, blk);
          end
        end
      end
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] blk, mixed, res;
    int lat;
    bit ok;
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 1000; n++) begin
        blk = rand_blk();
        mixed = model_mix(blk, 1'b0);
        send_block(d, mixed, res, lat, ok);
        if (ok) begin
          n_checks++;
          if (res !== blk || lat !== (4 >> d)) begin
            n_fail++;
            $display("FAIL round_trip dut%0d #%0d: got %h lat %0d expected %h lat %0d",
                     d, n, res, lat, blk, 4 >> d);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] blk, want;
    bit seen;
    blk = rand_blk();
    want = model_mix(blk, 1'b1);
    @(negedge clk);
    in_valid[0] = 1'b1;
    state_in[0] = blk;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = out_valid[0];
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL backpressure_timeout: out_valid=%b expected 1", out_valid[0]);
      return;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid[0] = i[0];
      state_in[0] = rand_blk();
      @(posedge clk); #1;
      n_checks++;
      if (out_valid[0] !== 1'b1 || state_out[0] !== want || in_ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold cycle %0d: out_valid=%b in_ready=%b state_out=%h expected 1 0 %h",
                 i, out_valid[0], in_ready[0], state_out[0], want);
      end
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    n_checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b expected 0 1", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] res, want;
    int lat;
    bit ok;
    @(negedge clk);
    in_valid[0] = 1'b1;
    state_in[0] = rand_blk();
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (fsm_state[0] !== ST_BUSY) begin
      n_fail++;
      $display("FAIL mid_busy_state: fsm=%0d expected BUSY", fsm_state[0]);
    end
    reset = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (state_out[0] !== '0 || out_valid[0] !== 1'b0 || fsm_state[0] !== ST_IDLE) begin
      n_fail++;
      $display("FAIL mid_busy_reset: state_out=%h out_valid=%b fsm=%0d expected 0 0 IDLE",
               state_out[0], out_valid[0], fsm_state[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    out_ready[0] = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_busy_discard: out_valid=%b expected 0", out_valid[0]);
      end
    end
    send_block(0, {4{32'h4d7ebdf8}}, res, lat, ok);
    want = {4{32'h2d26314c}};
    if (ok) begin
      n_checks++;
      if (res !== want) begin
        n_fail++;
        $display("FAIL after_reset_block: got %h expected %h", res, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] blk, exp_v;
    int last_acc, accepts, outputs;
    bit feeding;
    last_acc = -1;
    accepts = 0;
    outputs = 0;
    exp_q.delete();
    out_ready[0] = 1'b1;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      feeding = (i < 120);
      in_valid[0] = feeding;
      if (feeding && in_ready[0]) begin
        blk = rand_blk();
        state_in[0] = blk;
        exp_q.push_back(model_mix(blk, 1'b1));
        if (last_acc >= 0) begin
          n_checks++;
          if (i - last_acc !== 6) begin
            n_fail++;
            $display("FAIL b2b_interval: gap=%0d expected 6", i - last_acc);
          end
        end
        last_acc = i;
        accepts++;
      end
      if (out_valid[0]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_duplicate: got %h with no block outstanding", state_out[0]);
        end else begin
          exp_v = exp_q.pop_front();
          outputs++;
          if (state_out[0] !== exp_v) begin
            n_fail++;
            $display("FAIL b2b_result #%0d: got %h expected %h", outputs, state_out[0], exp_v);
          end
        end
      end
    end
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || accepts < 20 || outputs != accepts) begin
      n_fail++;
      $display("FAIL b2b_count: accepts=%0d outputs=%0d pending=%0d expected >=20 equal 0",
               accepts, outputs, exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b0;
      state_in[d] = '0;
    end
    test_reset();
    test_single();
    test_fixed_point();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    test_round_trip();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_mix_columns.md
INV_MIX_COLUMNS -- requirements
Module: inv_mix_columns

Interface
REQ-001 The block SHALL have parameter COLS_PER_CYCLE, default 1, giving columns processed per clock; legal values are 1, 2 and 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: state_in holds a valid block.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept input.
REQ-006 The block SHALL have port state_in, input, 128 bits: the MixColumns-domain state; column c is bits [127-32c -: 32], with row 0 in the top byte.
REQ-007 The block SHALL have port out_valid, output, 1 bit: state_out holds a result.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 The block SHALL have port state_out, output, 128 bits: the InvMixColumns result, with the same column and byte layout as state_in.

Function
REQ-010 For each column a0..a3 (row 0 first), the block SHALL compute, over GF(2^8) with modulus 0x11B:
- r0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
- r1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
- r2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
- r3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
REQ-011 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-012 in_ready SHALL be 1 only when the FSM is in IDLE and reset is high.
REQ-013 In IDLE, on in_valid=1 at a clock edge, the block SHALL capture state_in into a 128-bit working register, clear the column counter to 0, and go to BUSY.
REQ-014 Each BUSY edge SHALL replace COLS_PER_CYCLE columns in place (columns cnt .. cnt+COLS_PER_CYCLE-1) and advance cnt by COLS_PER_CYCLE.
REQ-015 The column counter SHALL be 2 bits wide and wrap to 0 after column 3.
REQ-016 On the BUSY edge that processes column 3, the FSM SHALL go to DONE.
REQ-017 The latency from the accept edge to out_valid=1 SHALL be 4/COLS_PER_CYCLE cycles, i.e. 4 cycles at the default value.
REQ-018 out_valid SHALL be 1 exactly in DONE, and state_out SHALL equal the working register at all times.
REQ-019 In DONE, state_out and out_valid SHALL remain stable until out_ready=1 at a clock edge; on that edge the FSM SHALL go to IDLE.
REQ-020 in_valid SHALL be ignored in BUSY and DONE; there is no bypass, so the earliest next accept is the cycle after the DONE->IDLE transition.
REQ-021 out_ready SHALL be ignored outside DONE.
REQ-022 Throughput SHALL be one block per 4/COLS_PER_CYCLE+2 cycles when out_ready is held high.
REQ-023 All GF multiplies SHALL be built from the xtime chain (x2, x4, x8) and XOR only; no generic multiplier and no lookup ROM.

Reset
REQ-024 With reset=0 at a rising edge, the block SHALL set: FSM to IDLE, cnt to 0, working register (state_out) to 0, out_valid to 0.
REQ-025 Reset asserted mid-BUSY or in DONE SHALL discard the block in flight with no output handshake.
REQ-026 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-027 Reset SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-028 Shared package aes_pkg SHALL hold the xtime function, the constant InvMixColumns coefficients 0e/0b/0d/09, and the FSM state typedef.
REQ-029 The design SHALL contain one sub-module, inv_mix_column: combinational, 32-bit column in to 32-bit column out.
REQ-030 The design SHALL instantiate COLS_PER_CYCLE copies of inv_mix_column, with a column-select mux driven by cnt.

Verification
REQ-031 Single block test: state_in=8e4da1bc_9fdc589d_01010101_d5d5d7d6 with out_ready=1 SHALL give out_valid in exactly 4 cycles, with state_out=db135345_f20a225c_01010101_d4d4d4d5.
REQ-032 Round-trip test: 1000 random blocks passed through the existing MixColumns model then this block SHALL each return the original block; repeat for COLS_PER_CYCLE=1, 2 and 4.
REQ-033 Backpressure test: with out_ready=0 for 10 cycles after out_valid, out_valid and state_out SHALL stay stable, in_ready SHALL stay 0, and in_valid pulses SHALL be ignored.
REQ-034 Reset test: reset=0 asserted at BUSY cnt=2 SHALL give state_out=0, out_valid=0 and IDLE next cycle; a new block 4d7ebdf8 replicated across all columns SHALL then give 2d26314c replicated across all columns.
REQ-035 Fixed-point test: state_in of all c6 bytes, and separately all 01 bytes, SHALL give an identical output.
REQ-036 Back-to-back test: in_valid and out_ready held high SHALL give one accept every 6 cycles at COLS_PER_CYCLE=1, with no dropped or duplicated blocks.
